uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//   Frame controller behind the UART byte receiver; consumes its Data/Rx_Done byte stream.
//   Frame: 0x55 0xA5 ADDR LEN D0..D(LEN-1) [CSUM]. Payload is buffered, then written to a
//   register bus. Address 0xFF also reprograms the receiver's Baud_Set, so the host can
//   retune the link over the link itself.
// PARAMETERS
//   MAX_LEN      8          max payload bytes per frame (buffer depth), 1..16
//   TIMEOUT_CYC  1000000    max idle Clk cycles between bytes inside a frame (20 ms @ 50 MHz)
// PORTS
//   Clk        in   1  system clock
//   Reset_n    in   1  asynchronous, active-low reset
//   Rx_Data    in   8  received byte, valid when Rx_Done=1
//   Rx_Done    in   1  one-cycle strobe: new byte on Rx_Data
//   Wr_En      out  1  register write strobe
//   Wr_Addr    out  8  write address
//   Wr_Data    out  8  write data
//   Baud_Set   out  3  baud select to receiver/transmitter (0=9600 ... 4=115200)
//   Busy       out  1  high in any state except IDLE
//   Frame_Ok   out  1  one-cycle pulse, frame committed
//   Frame_Err  out  1  one-cycle pulse, frame dropped
// BEHAVIOUR
//   - All outputs registered. Reset values: Wr_En=0, Wr_Addr=0, Wr_Data=0, Baud_Set=3'd0,
//     Busy=0, Frame_Ok=0, Frame_Err=0, FSM=IDLE, buffer/counters cleared.
//   - Reset mid-frame: frame discarded, no write issued, Baud_Set returns to 0.
//   - FSM acts only on cycles with Rx_Done=1, except COMMIT and timeout:
//     IDLE: 0x55->HDR2, else stay. HDR2: 0xA5->ADDR; 0x55->stay HDR2; else->IDLE (no Err).
//     ADDR: latch ADDR->LEN. LEN: 0 or >MAX_LEN -> Frame_Err, IDLE; else ->DATA, idx=0.
//     DATA: buf[idx]<=byte, idx++; after byte LEN-1 -> CSUM (or COMMIT if macro off).
//     CSUM: byte == (ADDR+LEN+sum(D)) mod 256 -> COMMIT; else Frame_Err, IDLE.
//     COMMIT: one write per cycle, idx 0..LEN-1, then IDLE. Rx_Done ignored in COMMIT.
//   - Checksum: 8-bit running sum, carries discarded; accumulated byte-by-byte.
//   - Latency: last frame byte's Rx_Done in cycle T -> Wr_En high cycles T+1..T+LEN,
//     Wr_Addr=ADDR+i (8-bit wrap, 0xFF->0x00), Wr_Data=buf[i]; Frame_Ok high in cycle T+LEN.
//   - Frame_Err is high in cycle T+1 after the offending byte/timeout cycle T.
//   - Baud: a write with Wr_Addr=0xFF and Wr_Data[7:3]=0, Wr_Data[2:0]<=4 sets
//     Baud_Set<=Wr_Data[2:0] in the same cycle Wr_En is high (visible next cycle);
//     other values: Wr_En still issued, Baud_Set unchanged.
//   - Timeout: counter cleared on every Rx_Done and in IDLE/COMMIT; counts in
//     HDR2..CSUM; on reaching TIMEOUT_CYC-1 -> Frame_Err, IDLE.
//     Rx_Done in the same cycle as expiry wins: byte accepted, counter cleared.
//   - Busy=1 in HDR2, ADDR, LEN, DATA, CSUM, COMMIT.
// CONFIGURATION
//   UART_FRAME_CSUM_EN defined: CSUM byte present and checked as above.
//   Not defined: no CSUM byte, CSUM state absent; DATA goes straight to COMMIT after the
//     last payload byte, same T+1 timing; Frame_Err only from LEN error or timeout.
// TESTING
//   (UART_FRAME_CSUM_EN defined, TIMEOUT_CYC reduced to 1000 in bench)
//   1. 55 A5 10 02 AB CD 8A -> Wr 0x10=AB, 0x11=CD in consecutive cycles; Frame_Ok once.
//   2. 55 A5 10 02 AB CD 8B -> Frame_Err pulse; no Wr_En; Busy=0 after.
//   3. 55 A5 FF 01 04 04 -> Wr 0xFF=04; Baud_Set=4. Then 55 A5 FF 01 07 07 -> Baud_Set stays 4.
//   4. 55 A5 FE 02 11 02 13 -> Wr 0xFE=11, 0xFF=02 (wrap); Baud_Set=2.
//   5. 55 A5 10, then 1000 idle cycles -> Frame_Err, IDLE; then 55 55 A5 20 01 33 54
//      -> HDR2 resync; Wr 0x20=33.
//   6. 55 A5 10 00 -> Frame_Err (LEN=0); 55 A5 10 09 -> Frame_Err (LEN>MAX_LEN);
//      Reset_n low mid-DATA -> all outputs at reset values, no write.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_ctrl
// Description : Frame controller behind the UART byte receiver. Parses
//               55 A5 ADDR LEN D0..D(LEN-1) [CSUM], buffers the payload and
//               replays it as consecutive register-bus writes. A write to
//               address 0xFF with a legal value (0..4) retunes Baud_Set.
// Options     : UART_FRAME_CSUM_EN - when defined, a trailing checksum byte
//               (ADDR+LEN+sum(D) mod 256) is expected and checked.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Done,
  output logic       Wr_En,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic [2:0] Baud_Set,
  output logic       Busy,
  output logic       Frame_Ok,
  output logic       Frame_Err
);

  // idx/len must hold 0..MAX_LEN; the buffer only needs 0..MAX_LEN-1
  localparam int IW        = $clog2(MAX_LEN + 1);
  localparam int AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BUF_DEPTH = 1 << AW;
  localparam int TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0]    SYNC1     = 8'h55;
  localparam logic [7:0]    SYNC2     = 8'hA5;
  localparam logic [7:0]    BAUD_ADDR = 8'hFF;
  localparam logic [2:0]    BAUD_MAX  = 3'd4;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR2   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_LEN    = 3'd3,
    ST_DATA   = 3'd4,
    ST_COMMIT = 3'd5
`ifdef UART_FRAME_CSUM_EN
    ,
    ST_CSUM   = 3'd6
`endif
  } state_t;

  state_t         state;
  state_t         next_state;

  logic [7:0]     addr_q;
  logic [IW-1:0]  len_q;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  last_idx;
  logic [7:0]     buf_mem [BUF_DEPTH];
  logic [TW-1:0]  tmo_cnt;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]     csum;
`endif

  logic           counting;
  logic           tmo_hit;
  logic           issue;
  logic [IW-1:0]  issue_idx;
  logic [7:0]     issue_data;
  logic           frame_done;
  logic           drop;

  assign last_idx = len_q - IW'(1);
  assign counting = (state != ST_IDLE) && (state != ST_COMMIT);
  assign tmo_hit  = counting && !Rx_Done && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state decode; also decides which buffered byte is written next.
  // A write is issued one cycle before it appears on the bus, so the first
  // write is issued on the cycle that accepts the last frame byte.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    issue_idx  = '0;
    frame_done = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Rx_Done && (Rx_Data == SYNC1)) next_state = ST_HDR2;
      end
      ST_HDR2: begin
        if (Rx_Done) begin
          if (Rx_Data == SYNC2)      next_state = ST_ADDR;
          else if (Rx_Data == SYNC1) next_state = ST_HDR2;
          else                       next_state = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (Rx_Done) next_state = ST_LEN;
      end
      ST_LEN: begin
        if (Rx_Done) begin
          if ((Rx_Data == 8'd0) || (Rx_Data > 8'(MAX_LEN))) begin
            drop       = 1'b1;
            next_state = ST_IDLE;
          end else begin
            next_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (Rx_Done && (idx == last_idx)) begin
`ifdef UART_FRAME_CSUM_EN
          next_state = ST_CSUM;
`else
          next_state = ST_COMMIT;
          issue      = 1'b1;
          frame_done = (len_q == IW'(1));
`endif
        end
      end
`ifdef UART_FRAME_CSUM_EN
      ST_CSUM: begin
        if (Rx_Done) begin
          if (Rx_Data == csum) begin
            next_state = ST_COMMIT;
            issue      = 1'b1;
            frame_done = (len_q == IW'(1));
          end else begin
            drop       = 1'b1;
            next_state = ST_IDLE;
          end
        end
      end
`endif
      ST_COMMIT: begin
        if (idx < len_q) begin
          issue      = 1'b1;
          issue_idx  = idx;
          frame_done = (idx == last_idx);
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // Inter-byte timeout abandons the frame; a byte arriving on the expiry
    // cycle masks tmo_hit, so the byte wins.
    if (tmo_hit) begin
      drop       = 1'b1;
      next_state = ST_IDLE;
    end
  end

  // Data for the issued write; a single-byte payload is written straight
  // from Rx_Data because it lands in the buffer on the same edge.
  always_comb begin
    issue_data = buf_mem[issue_idx[AW-1:0]];
    if ((state == ST_DATA) && (idx == '0)) issue_data = Rx_Data;
  end

  // Frame bookkeeping: address, length, payload buffer, index, checksum
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q <= '0;
      len_q  <= '0;
      idx    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
`ifdef UART_FRAME_CSUM_EN
      csum   <= '0;
`endif
    end else begin
      if ((state == ST_ADDR) && Rx_Done) addr_q <= Rx_Data;
      if ((state == ST_LEN) && Rx_Done) begin
        len_q <= Rx_Data[IW-1:0];
        idx   <= '0;
      end
      if ((state == ST_DATA) && Rx_Done) buf_mem[idx[AW-1:0]] <= Rx_Data;
      if (issue)                              idx <= issue_idx + IW'(1);
      else if ((state == ST_DATA) && Rx_Done) idx <= idx + IW'(1);
`ifdef UART_FRAME_CSUM_EN
      if (Rx_Done) begin
        if (state == ST_ADDR)                           csum <= Rx_Data;
        else if ((state == ST_LEN) || (state == ST_DATA)) csum <= csum + Rx_Data;
      end
`endif
    end
  end

  // Inter-byte idle counter, active only while a frame is being received
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                          tmo_cnt <= '0;
    else if (!counting || Rx_Done || tmo_hit) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Registered bus outputs, status pulses and baud select
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Wr_En     <= 1'b0;
      Wr_Addr   <= '0;
      Wr_Data   <= '0;
      Baud_Set  <= 3'd0;
      Busy      <= 1'b0;
      Frame_Ok  <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      Wr_En     <= issue;
      Frame_Ok  <= frame_done;
      Frame_Err <= drop;
      Busy      <= (next_state != ST_IDLE);
      if (issue) begin
        Wr_Addr <= addr_q + 8'(issue_idx);
        Wr_Data <= issue_data;
      end
      if (Wr_En && (Wr_Addr == BAUD_ADDR) && (Wr_Data[7:3] == 5'd0) &&
          (Wr_Data[2:0] <= BAUD_MAX))
        Baud_Set <= Wr_Data[2:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame_ctrl
// Description : Directed bench for uart_rx_frame_ctrl (MAX_LEN=8,
//               TIMEOUT_CYC=1000). Frames carry a checksum byte only when
//               UART_FRAME_CSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] Rx_Data;
  logic       Rx_Done;
  logic       Wr_En;
  logic [7:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic [2:0] Baud_Set;
  logic       Busy;
  logic       Frame_Ok;
  logic       Frame_Err;

  int checks;
  int errors;
  int wr_seen;
  int ok_seen;
  int err_seen;
  logic [7:0] tx_q [$];

  uart_rx_frame_ctrl #(.MAX_LEN(8), .TIMEOUT_CYC(1000)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Rx_Data(Rx_Data), .Rx_Done(Rx_Done),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Baud_Set(Baud_Set),
    .Busy(Busy), .Frame_Ok(Frame_Ok), .Frame_Err(Frame_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse counters sampled mid-cycle
  always @(negedge Clk) begin
    if (Wr_En)     wr_seen++;
    if (Frame_Ok)  ok_seen++;
    if (Frame_Err) err_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // Byte is valid for exactly one cycle; returns 1 time unit into the next cycle
  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1;
    Rx_Data = b;
    Rx_Done = 1'b1;
    @(posedge Clk); #1;
    Rx_Done = 1'b0;
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i]);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Rx_Data = 8'h00; Rx_Done = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data, Frame_Ok, Frame_Err} !== 19'd0) begin
      errors++;
      $display("FAIL reset_bus got %b/%h/%h/%b/%b required 0/00/00/0/0", Wr_En, Wr_Addr, Wr_Data, Frame_Ok, Frame_Err);
    end
    checks++;
    if (Baud_Set !== 3'd0) begin errors++; $display("FAIL reset_baud got %0d required 0", Baud_Set); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", Busy); end
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_good_frame();
    int w0, o0;
    w0 = wr_seen; o0 = ok_seen;
    send_byte(8'h55);
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL good_busy_hdr got %b required 1", Busy); end
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'hAB, 8'hCD};
`ifdef UART_FRAME_CSUM_EN
    tx_q.push_back(8'h8A);
`endif
    send_q();
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data, Frame_Ok} !== {1'b1, 8'h10, 8'hAB, 1'b0}) begin
      errors++;
      $display("FAIL good_wr0 got en=%b a=%h d=%h ok=%b required 1/10/ab/0", Wr_En, Wr_Addr, Wr_Data, Frame_Ok);
    end
    step();
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data, Frame_Ok} !== {1'b1, 8'h11, 8'hCD, 1'b1}) begin
      errors++;
      $display("FAIL good_wr1 got en=%b a=%h d=%h ok=%b required 1/11/cd/1", Wr_En, Wr_Addr, Wr_Data, Frame_Ok);
    end
    step();
    checks++;
    if ({Wr_En, Frame_Ok, Busy} !== 3'b000) begin
      errors++;
      $display("FAIL good_end got en=%b ok=%b busy=%b required 0/0/0", Wr_En, Frame_Ok, Busy);
    end
    step();
    checks++;
    if ((wr_seen - w0) != 2 || (ok_seen - o0) != 1) begin
      errors++;
      $display("FAIL good_counts got wr=%0d ok=%0d required 2/1", wr_seen - w0, ok_seen - o0);
    end
  endtask

`ifdef UART_FRAME_CSUM_EN
  task automatic test_bad_csum();
    int w0;
    w0 = wr_seen;
    tx_q = '{8'h55, 8'hA5, 8'h10, 8'h02, 8'hAB, 8'hCD, 8'h8B};
    send_q();
    checks++;
    if ({Frame_Err, Wr_En} !== 2'b10) begin
      errors++;
      $display("FAIL csum_err got err=%b en=%b required 1/0", Frame_Err, Wr_En);
    end
    step();
    checks++;
    if ({Frame_Err, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL csum_after got err=%b busy=%b required 0/0", Frame_Err, Busy);
    end
    repeat (3) step();
    checks++;
    if (wr_seen != w0) begin errors++; $display("FAIL csum_nowrite got %0d writes required 0", wr_seen - w0); end
  endtask
`endif

  task automatic test_max_len();
    tx_q = '{8'h55, 8'hA5, 8'h30, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef UART_FRAME_CSUM_EN
    tx_q.push_back(8'h5C);
`endif
    send_q();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({Wr_En, Wr_Addr, Wr_Data, Frame_Ok} !== {1'b1, 8'h30 + 8'(i), 8'(i + 1), (i == 7)}) begin
        errors++;
        $display("FAIL maxlen_wr%0d got en=%b a=%h d=%h ok=%b required 1/%h/%h/%b", i, Wr_En, Wr_Addr, Wr_Data, Frame_Ok, 8'h30 + 8'(i), 8'(i + 1), (i == 7));
      end
      step();
    end
    checks++;
    if ({Wr_En, Busy} !== 2'b00) begin errors++; $display("FAIL maxlen_end got en=%b busy=%b required 0/0", Wr_En, Busy); end
  endtask

  task automatic test_baud();
    tx_q = '{8'h55, 8'hA5, 8'hFF, 8'h01, 8'h04};
`ifdef UART_FRAME_CSUM_EN
    tx_q.push_back(8'h04);
`endif
    send_q();
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data, Frame_Ok, Baud_Set} !== {1'b1, 8'hFF, 8'h04, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL baud_wr got en=%b a=%h d=%h ok=%b baud=%0d required 1/ff/04/1/0", Wr_En, Wr_Addr, Wr_Data, Frame_Ok, Baud_Set);
    end
    step();
    checks++;
    if (Baud_Set !== 3'd4) begin errors++; $display("FAIL baud_set4 got %0d required 4", Baud_Set); end
    tx_q = '{8'h55, 8'hA5, 8'hFF, 8'h01, 8'h07};
`ifdef UART_FRAME_CSUM_EN
    tx_q.push_back(8'h07);
`endif
    send_q();
    checks++;
    if ({Wr_En, Wr_Data} !== {1'b1, 8'h07}) begin
      errors++;
      $display("FAIL baud_bad_wr got en=%b d=%h required 1/07", Wr_En, Wr_Data);
    end
    step();
    checks++;
    if (Baud_Set !== 3'd4) begin errors++; $display("FAIL baud_keep got %0d required 4", Baud_Set); end
  endtask

  task automatic test_wrap();
    tx_q = '{8'h55, 8'hA5, 8'hFE, 8'h02, 8'h11, 8'h02};
`ifdef UART_FRAME_CSUM_EN
    tx_q.push_back(8'h13);
`endif
    send_q();
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data} !== {1'b1, 8'hFE, 8'h11}) begin
      errors++;
      $display("FAIL wrap_wr0 got en=%b a=%h d=%h required 1/fe/11", Wr_En, Wr_Addr, Wr_Data);
    end
    step();
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data, Baud_Set} !== {1'b1, 8'hFF, 8'h02, 3'd4}) begin
      errors++;
      $display("FAIL wrap_wr1 got en=%b a=%h d=%h baud=%0d required 1/ff/02/4", Wr_En, Wr_Addr, Wr_Data, Baud_Set);
    end
    step();
    checks++;
    if (Baud_Set !== 3'd2) begin errors++; $display("FAIL wrap_baud got %0d required 2", Baud_Set); end
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    tx_q = '{8'h55, 8'hA5, 8'h10};
    send_q();
    // Last byte in cycle T0; now at T0+1. Expiry on the 1000th idle cycle -> error in T0+1001
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 1100) begin
      if (Frame_Err === 1'b1) seen = 1'b1;
      else begin step(); cyc++; end
    end
    checks++;
    if (!seen || cyc != 1001) begin
      errors++;
      $display("FAIL timeout_err got seen=%b at cycle %0d required seen=1 at cycle 1001", seen, cyc);
    end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b required 0", Busy); end
    tx_q = '{8'h55, 8'h55, 8'hA5, 8'h20, 8'h01, 8'h33};
`ifdef UART_FRAME_CSUM_EN
    tx_q.push_back(8'h54);
`endif
    send_q();
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data, Frame_Ok} !== {1'b1, 8'h20, 8'h33, 1'b1}) begin
      errors++;
      $display("FAIL resync_wr got en=%b a=%h d=%h ok=%b required 1/20/33/1", Wr_En, Wr_Addr, Wr_Data, Frame_Ok);
    end
    step();
  endtask

  task automatic test_len_err();
    tx_q = '{8'h55, 8'hA5, 8'h10, 8'h00};
    send_q();
    checks++;
    if ({Frame_Err, Busy, Wr_En} !== 3'b100) begin
      errors++;
      $display("FAIL len0 got err=%b busy=%b en=%b required 1/0/0", Frame_Err, Busy, Wr_En);
    end
    tx_q = '{8'h55, 8'hA5, 8'h10, 8'h09};
    send_q();
    checks++;
    if ({Frame_Err, Busy, Wr_En} !== 3'b100) begin
      errors++;
      $display("FAIL len9 got err=%b busy=%b en=%b required 1/0/0", Frame_Err, Busy, Wr_En);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    int w0;
    w0 = wr_seen;
    tx_q = '{8'h55, 8'hA5, 8'h40, 8'h03, 8'hAA, 8'hBB};
    send_q();
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b required 1", Busy); end
    Reset_n = 1'b0;
    #2;
    checks++;
    if ({Wr_En, Wr_Addr, Wr_Data, Baud_Set, Busy, Frame_Ok, Frame_Err} !== 23'd0) begin
      errors++;
      $display("FAIL mid_reset got en=%b a=%h d=%h baud=%0d busy=%b ok=%b err=%b required all 0", Wr_En, Wr_Addr, Wr_Data, Baud_Set, Busy, Frame_Ok, Frame_Err);
    end
    step();
    Reset_n = 1'b1;
    tx_q = '{8'hCC};
`ifdef UART_FRAME_CSUM_EN
    tx_q.push_back(8'h0E);
`endif
    send_q();
    repeat (4) step();
    checks++;
    if ((wr_seen != w0) || (Baud_Set !== 3'd0) || (Busy !== 1'b0)) begin
      errors++;
      $display("FAIL mid_nowrite got writes=%0d baud=%0d busy=%b required 0/0/0", wr_seen - w0, Baud_Set, Busy);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    wr_seen = 0; ok_seen = 0; err_seen = 0;
    test_reset();
    test_good_frame();
`ifdef UART_FRAME_CSUM_EN
    test_bad_csum();
`endif
    test_max_len();
    test_baud();
    test_wrap();
    test_timeout();
    test_len_err();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
